change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have the parameter PULSE_CYCLES, default 2: number of cycles each coin drive pulse is held, legal range 1..7.
REQ-002 The block SHALL have the parameter BIG_VALUE, default 5: value of one big coin in change units, legal range 2..15.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 15: maximum number of cycles spent waiting for Hopper_Ack, legal range 1..255.
REQ-004 The block SHALL have the port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port Change, input, 5 bits: amount of change owed by the vending controller, in units.
REQ-007 The block SHALL have the port Change_Valid, input, 1 bit: a one-cycle strobe that qualifies Change.
REQ-008 The block SHALL have the port Hopper_Ack, input, 1 bit: a one-cycle strobe from the coin hopper meaning "coin dropped".
REQ-009 The block SHALL have the port Clear, input, 1 bit: synchronous release from FAULT.
REQ-010 The block SHALL have the port Coin_Big, output, 1 bit: drive pulse for the big-coin hopper.
REQ-011 The block SHALL have the port Coin_Small, output, 1 bit: drive pulse for the 1-unit hopper.
REQ-012 The block SHALL have the port Busy, output, 1 bit: high while a dispense is in progress.
REQ-013 The block SHALL have the port Done, output, 1 bit: a one-cycle pulse on completion.
REQ-014 The block SHALL have the port Fault, output, 1 bit: high and held after a hopper timeout.
REQ-015 The block SHALL have the port Remaining, output, 5 bits: change still owed.

Function
REQ-016 The block SHALL implement a state machine with the states IDLE, PULSE, WAIT_ACK, DONE and FAULT.
REQ-017 In IDLE, if Change_Valid=1 and Change!=0 at edge k, the block SHALL load Remaining=Change, set Busy=1 and enter PULSE, with the first coin output rising at edge k+1.
REQ-018 In IDLE, if Change_Valid=1 and Change=0, the block SHALL enter DONE and drive no coin pulse.
REQ-019 Coin selection SHALL be greedy: Coin_Big if Remaining>=BIG_VALUE, else Coin_Small; Coin_Big and Coin_Small SHALL never be high together.
REQ-020 In PULSE, the selected coin output SHALL be held high for exactly PULSE_CYCLES cycles, after which the block SHALL enter WAIT_ACK with both coin outputs low.
REQ-021 In WAIT_ACK, on Hopper_Ack=1 the block SHALL subtract the value of the dispensed coin from Remaining (5-bit arithmetic, never underflowing); if the result is 0 it SHALL enter DONE, otherwise it SHALL return to PULSE for the next coin.
REQ-022 Hopper_Ack SHALL be ignored in every state except WAIT_ACK.
REQ-023 In WAIT_ACK, a counter SHALL count the cycles elapsed without an acknowledge; when TIMEOUT_CYCLES is reached the block SHALL enter FAULT.
REQ-024 If Hopper_Ack arrives in the same cycle as timeout expiry, the acknowledge SHALL win.
REQ-025 DONE SHALL last one cycle with Done=1, Busy=0 and Remaining=0, then return to IDLE.
REQ-026 In FAULT, the block SHALL hold Fault=1 and Busy=0, keep Remaining frozen, and drive no coin pulses.
REQ-027 In FAULT, Clear=1 SHALL return the block to IDLE and set Fault=0; Remaining SHALL keep its frozen value until the next load.
REQ-028 Change_Valid received outside IDLE SHALL be ignored, with no queuing and no change to Remaining.
REQ-029 Clear outside FAULT SHALL have no effect.
REQ-030 Busy SHALL be high in PULSE and WAIT_ACK only.

Reset
REQ-031 While Reset=1, the block SHALL asynchronously force state=IDLE, Coin_Big=0, Coin_Small=0, Busy=0, Done=0, Fault=0, Remaining=0, and clear the pulse and timeout counters.
REQ-032 A reset asserted mid-dispense SHALL abort the dispense immediately, with no further coin pulses.
REQ-033 After reset release, the first usable Change_Valid SHALL be the one sampled at the first rising edge after Reset falls.

Verification
REQ-034 The bench SHALL cover: Change=7 strobe, hopper acking 3 cycles after each pulse -> 1 Coin_Big and 2 Coin_Small pulses, each 2 cycles long; Remaining 7->2->1->0; one Done pulse.
REQ-035 The bench SHALL cover: Change=0 strobe -> Done=1 on the next cycle, no coin pulses, Busy stays 0.
REQ-036 The bench SHALL cover: Change=31 -> 6 Coin_Big and 1 Coin_Small; a Change_Valid with Change=4 strobed during the dispense is ignored and the final Remaining is 0.
REQ-037 The bench SHALL cover: Change=3 with no Hopper_Ack -> Fault=1 exactly 15 cycles after WAIT_ACK entry with Remaining=3; Clear -> IDLE; a new Change=1 then dispenses normally.
REQ-038 The bench SHALL cover: Hopper_Ack coincident with the timeout cycle -> no Fault and the dispense continues.
REQ-039 The bench SHALL cover: Reset asserted during a Coin_Big pulse -> all outputs 0 asynchronously, with no pulse after release.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: greedy big/small coin hopper sequencer
// with per-coin drive pulse, ack timeout and fault latch.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 2,
  parameter int BIG_VALUE      = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] Change,
  input  logic       Change_Valid,
  input  logic       Hopper_Ack,
  input  logic       Clear,
  output logic       Coin_Big,
  output logic       Coin_Small,
  output logic       Busy,
  output logic       Done,
  output logic       Fault,
  output logic [4:0] Remaining
);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  localparam logic [4:0] BIG_V   = 5'(BIG_VALUE);
  localparam logic [2:0] PULSE_N = 3'(PULSE_CYCLES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [2:0] pulse_cnt;
  logic [7:0] tmo_cnt;
  logic       use_big;
  logic [4:0] coin_val;
  logic [4:0] rem_next;

  // Greedy pick; Remaining is stable through PULSE and WAIT_ACK
  assign use_big  = (Remaining >= BIG_V);
  assign coin_val = use_big ? BIG_V : 5'd1;
  assign rem_next = (Remaining > coin_val) ?
                    (Remaining - coin_val) : 5'd0;

  // Dispense sequencer with registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      tmo_cnt    <= '0;
      Coin_Big   <= 1'b0;
      Coin_Small <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Fault      <= 1'b0;
      Remaining  <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Change_Valid) begin
            if (Change != 5'd0) begin
              Remaining <= Change;
              Busy      <= 1'b1;
              pulse_cnt <= '0;
              state     <= PULSE;
            end else begin
              Remaining <= '0;
              Done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        PULSE: begin
          if (pulse_cnt == PULSE_N) begin
            Coin_Big   <= 1'b0;
            Coin_Small <= 1'b0;
            tmo_cnt    <= '0;
            state      <= WAIT_ACK;
          end else begin
            Coin_Big   <= use_big;
            Coin_Small <= ~use_big;
            pulse_cnt  <= pulse_cnt + 3'd1;
          end
        end
        WAIT_ACK: begin
          if (Hopper_Ack) begin
            Remaining <= rem_next;
            if (rem_next == 5'd0) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              pulse_cnt <= '0;
              state     <= PULSE;
            end
          end else if (tmo_cnt == TO_LAST) begin
            Busy  <= 1'b0;
            Fault <= 1'b1;
            state <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          if (Clear) begin
            Fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
